qtree_loader: RTL and testbench

- Control-plane writer for the quad-tree lookup pipeline; drives the RAM write side of every lookup stage.
- Accepts host commands over a valid/ready handshake: write one node's l/m/r keys into a chosen stage, or clear the whole tree.
- Converts each command into per-stage single-cycle RAM write strobes on a shared write address/data bus.
- Sits between the host register block and the chain of lookup stages.

---
 rtl/qtree_loader_if.sv | 34 +++
 rtl/qtree_loader.sv | 153 +++++++++++++++
 tb/tb_qtree_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/qtree_loader_if.sv
// Host command channel and shared stage-RAM write bus of the quad-tree loader.
// The master side is the host; the slave side is the loader.
interface qtree_loader_if #(
  parameter int STAGES  = 4,
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 16
);
  localparam int S_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic                   cmd_op_i;
  logic [S_W-1:0]         cmd_stage_i;
  logic [A_WIDTH-1:0]     cmd_addr_i;
  logic [D_WIDTH-1:0]     cmd_l_i;
  logic [D_WIDTH-1:0]     cmd_m_i;
  logic [D_WIDTH-1:0]     cmd_r_i;
  logic [STAGES-1:0]      wr_en_o;
  logic [A_WIDTH-1:0]     wr_addr_o;
  logic [3*D_WIDTH-1:0]   wr_data_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   err_o;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_stage_i, cmd_addr_i, cmd_l_i, cmd_m_i, cmd_r_i,
    input  cmd_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_stage_i, cmd_addr_i, cmd_l_i, cmd_m_i, cmd_r_i,
    output cmd_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/qtree_loader.sv
// Control-plane writer for the quad-tree lookup stages: turns host node writes and
// whole-tree clears into one-cycle per-stage RAM write strobes on a shared bus.
module qtree_loader #(
  parameter int                  STAGES    = 4,
  parameter int                  A_WIDTH   = 8,
  parameter int                  D_WIDTH   = 16,
  parameter logic [D_WIDTH-1:0]  CLEAR_VAL = {D_WIDTH{1'b1}}
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  qtree_loader_if.slave bus
);
  localparam int S_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int AW1 = A_WIDTH + 1;
  localparam logic [S_W-1:0]       LAST_STAGE = S_W'(STAGES - 1);
  localparam logic [3*D_WIDTH-1:0] CLEAR_WORD = {CLEAR_VAL, CLEAR_VAL, CLEAR_VAL};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Entry count of a stage: 2 for stage 0, 4^s otherwise; one extra bit so 2^A_WIDTH fits.
  function automatic logic [AW1-1:0] stage_depth(input logic [S_W-1:0] stg);
    logic [AW1-1:0] d;
    if (stg == '0) begin
      d = AW1'(2);
    end else begin
      d = AW1'(1) << {stg, 1'b0};
    end
    return d;
  endfunction

  function automatic logic [STAGES-1:0] onehot(input logic [S_W-1:0] stg);
    logic [STAGES-1:0] oh;
    oh    = '0;
    oh[0] = 1'b1;
    return oh << stg;
  endfunction

  state_e               state_q, state_d;
  logic [S_W-1:0]       stg_q, stg_d;
  logic [A_WIDTH-1:0]   cnt_q, cnt_d;
  logic [STAGES-1:0]    wr_en_q, wr_en_d;
  logic [A_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [3*D_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 cmd_legal_s;
  logic [AW1-1:0]       depth_m1_s;

  // State, counters and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      stg_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stg_q     <= stg_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    stg_d       = stg_q;
    cnt_d       = cnt_q;
    wr_en_d     = '0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cmd_legal_s = (int'(bus.cmd_stage_i) < STAGES) &&
                  ({1'b0, bus.cmd_addr_i} < stage_depth(bus.cmd_stage_i));
    depth_m1_s  = stage_depth(stg_q) - AW1'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          if (bus.cmd_op_i) begin
            // The first clear write leaves straight from IDLE so busy_o spans only write cycles.
            state_d   = ST_CLEAR;
            stg_d     = '0;
            cnt_d     = A_WIDTH'(1);
            wr_en_d   = onehot('0);
            wr_addr_d = '0;
            wr_data_d = CLEAR_WORD;
            busy_d    = 1'b1;
          end else if (cmd_legal_s) begin
            wr_en_d   = onehot(bus.cmd_stage_i);
            wr_addr_d = bus.cmd_addr_i;
            wr_data_d = {bus.cmd_l_i, bus.cmd_m_i, bus.cmd_r_i};
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        wr_en_d   = onehot(stg_q);
        wr_addr_d = cnt_q;
        wr_data_d = CLEAR_WORD;
        busy_d    = 1'b1;
        if ({1'b0, cnt_q} == depth_m1_s) begin
          cnt_d = '0;
          if (stg_q == LAST_STAGE) begin
            state_d = ST_DONE;
          end else begin
            stg_d = stg_q + S_W'(1);
          end
        end else begin
          cnt_d = cnt_q + A_WIDTH'(1);
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready_o = rst_n_i & (state_q == ST_IDLE);
  assign bus.wr_en_o     = wr_en_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_qtree_loader.sv
// Scoreboard bench for qtree_loader: stimulus pushes expected bus events with their
// expected cycle, a negedge monitor pops and compares every strobe/pulse the DUT shows.
module tb_qtree_loader;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  qtree_loader_if #(.STAGES(4), .A_WIDTH(8), .D_WIDTH(16)) bus ();
  qtree_loader #(.STAGES(4), .A_WIDTH(8), .D_WIDTH(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
  );

  // A three-stage instance is the only way to present an out-of-range stage index.
  qtree_loader_if #(.STAGES(3), .A_WIDTH(8), .D_WIDTH(16)) bus3 ();
  qtree_loader #(.STAGES(3), .A_WIDTH(8), .D_WIDTH(16)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus3)
  );

  typedef struct {
    string       nm;
    logic [3:0]  en;
    logic [7:0]  addr;
    logic [47:0] data;
    logic        busy;
    logic        err;
    logic        done;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [7:0]  last_addr = 8'd0;
  logic [47:0] last_data = 48'd0;
  int          dep[4] = '{2, 4, 16, 64};

  function automatic void push(input string nm, input logic [3:0] en, input logic [7:0] addr,
                               input logic [47:0] data, input logic busy, input logic err,
                               input logic done, input int at);
    exp_t x;
    if (en != 4'd0) begin
      last_addr = addr;
      last_data = data;
    end
    x.nm = nm; x.en = en; x.addr = last_addr; x.data = last_data;
    x.busy = busy; x.err = err; x.done = done; x.at = at;
    exp_q.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  // Issue one command at a negedge; exp_en=0 means the write must be rejected with err_o.
  task automatic send(input logic op, input logic [1:0] stg, input logic [7:0] addr,
                      input logic [15:0] l, input logic [15:0] m, input logic [15:0] r,
                      input logic [3:0] exp_en, input string nm, output int acc);
    int n;
    int k;
    bus.cmd_op_i = op; bus.cmd_stage_i = stg; bus.cmd_addr_i = addr;
    bus.cmd_l_i = l; bus.cmd_m_i = m; bus.cmd_r_i = r;
    bus.cmd_valid_i = 1'b1;
    n = 0;
    while (!bus.cmd_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready_o) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout got=not_ready required=ready", nm);
      bus.cmd_valid_i = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      if (op) begin
        k = 0;
        for (int s = 0; s < 4; s++) begin
          for (int a = 0; a < dep[s]; a++) begin
            push($sformatf("%s_s%0da%0d", nm, s, a), 4'b0001 << s, 8'(a),
                 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, acc + 1 + k);
            k++;
          end
        end
        push({nm, "_done"}, 4'd0, 8'd0, 48'd0, 1'b0, 1'b0, 1'b1, acc + 87);
      end else if (exp_en != 4'd0) begin
        push(nm, exp_en, addr, {l, m, r}, 1'b0, 1'b0, 1'b0, acc + 1);
      end else begin
        push(nm, 4'd0, 8'd0, 48'd0, 1'b0, 1'b1, 1'b0, acc + 1);
      end
      @(negedge clk);
    end
  endtask

  // Monitor: every strobe or pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy_o) busy_cnt++;
      if (bus.wr_en_o != 4'd0 || bus.err_o || bus.done_o) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cyc=%0d got en=%b addr=%0d err=%b done=%b required=none",
                   cyc, bus.wr_en_o, bus.wr_addr_o, bus.err_o, bus.done_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.wr_en_o !== e.en || bus.wr_addr_o !== e.addr || bus.wr_data_o !== e.data ||
              bus.busy_o !== e.busy || bus.err_o !== e.err || bus.done_o !== e.done ||
              cyc != e.at) begin
            bad++;
            $display("FAIL %s got cyc=%0d en=%b addr=%0d data=%h busy=%b err=%b done=%b required cyc=%0d en=%b addr=%0d data=%h busy=%b err=%b done=%b",
                     e.nm, cyc, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, bus.busy_o,
                     bus.err_o, bus.done_o, e.at, e.en, e.addr, e.data, e.busy, e.err, e.done);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, a2, ac, ah;
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 1'b0; bus.cmd_stage_i = 2'd0; bus.cmd_addr_i = 8'd0;
    bus.cmd_l_i = 16'd0; bus.cmd_m_i = 16'd0; bus.cmd_r_i = 16'd0;
    bus3.cmd_valid_i = 1'b0; bus3.cmd_op_i = 1'b0; bus3.cmd_stage_i = 2'd0; bus3.cmd_addr_i = 8'd0;
    bus3.cmd_l_i = 16'd0; bus3.cmd_m_i = 16'd0; bus3.cmd_r_i = 16'd0;

    #12;
    chk("reset_ctrl", {bus.wr_en_o, bus.busy_o, bus.done_o, bus.err_o, bus.cmd_ready_o}, 64'd0);
    chk("reset_addr", bus.wr_addr_o, 64'd0);
    chk("reset_data", bus.wr_data_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_ready_o, 64'd1);

    send(1'b0, 2'd2, 8'd5, 16'h0010, 16'h0020, 16'h0030, 4'b0100, "w_s2a5", a0);
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    send(1'b0, 2'd0, 8'd1, 16'h1111, 16'h2222, 16'h3333, 4'b0001, "b2b_s0", a0);
    send(1'b0, 2'd1, 8'd3, 16'hAAAA, 16'hBBBB, 16'hCCCC, 4'b0010, "b2b_s1", a1);
    send(1'b0, 2'd3, 8'd63, 16'h1234, 16'h5678, 16'h9ABC, 4'b1000, "b2b_s3", a2);
    bus.cmd_valid_i = 1'b0;
    chk("b2b_accept_spacing", a2 - a0, 64'd2);
    repeat (2) @(negedge clk);

    send(1'b0, 2'd0, 8'd2, 16'hDEAD, 16'hBEEF, 16'hF00D, 4'd0, "ill_s0a2", a0);
    send(1'b0, 2'd1, 8'd4, 16'hDEAD, 16'hBEEF, 16'hF00D, 4'd0, "ill_s1a4", a0);
    send(1'b0, 2'd2, 8'd16, 16'hDEAD, 16'hBEEF, 16'hF00D, 4'd0, "ill_s2a16", a0);
    send(1'b0, 2'd3, 8'd64, 16'hDEAD, 16'hBEEF, 16'hF00D, 4'd0, "ill_s3a64", a0);
    send(1'b0, 2'd2, 8'd15, 16'h0F0F, 16'hF0F0, 16'h5A5A, 4'b0100, "edge_s2a15", a0);
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    bus3.cmd_stage_i = 2'd3; bus3.cmd_addr_i = 8'd0; bus3.cmd_valid_i = 1'b1;
    chk("s3_ready", bus3.cmd_ready_o, 64'd1);
    @(negedge clk);
    bus3.cmd_valid_i = 1'b0;
    chk("ill_stage_err", {bus3.err_o, bus3.wr_en_o}, {60'd0, 1'b1, 3'b000});
    @(negedge clk);
    chk("ill_stage_err_pulse", bus3.err_o, 64'd0);

    busy_cnt = 0;
    send(1'b1, 2'd3, 8'd77, 16'h0, 16'h0, 16'h0, 4'd0, "clr1", ac);
    send(1'b0, 2'd1, 8'd2, 16'h0102, 16'h0304, 16'h0506, 4'b0010, "held_w", ah);
    bus.cmd_valid_i = 1'b0;
    chk("held_accept_cyc", ah - ac, 64'd87);
    repeat (3) @(negedge clk);
    chk("clr1_busy_cycles", busy_cnt, 64'd86);

    send(1'b1, 2'd0, 8'd0, 16'h0, 16'h0, 16'h0, 4'd0, "clr2", ac);
    bus.cmd_valid_i = 1'b0;
    repeat (39) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midclr_reset_ctrl", {bus.wr_en_o, bus.busy_o, bus.done_o, bus.err_o, bus.cmd_ready_o}, 64'd0);
    chk("midclr_reset_bus", {bus.wr_addr_o, bus.wr_data_o}, 64'd0);
    exp_q.delete();
    last_addr = 8'd0;
    last_data = 48'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    busy_cnt = 0;
    send(1'b1, 2'd1, 8'd9, 16'h0, 16'h0, 16'h0, 4'd0, "clr3", ac);
    bus.cmd_valid_i = 1'b0;
    repeat (95) @(negedge clk);
    chk("clr3_busy_cycles", busy_cnt, 64'd86);

    send(1'b0, 2'd3, 8'd0, 16'h7777, 16'h8888, 16'h9999, 4'b1000, "post_w", a0);
    bus.cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
